// File: rtl/ccff_loader_pkg.sv
// -----------------------------------------------------------------------------
// ccff_loader_pkg
//   Shared types for the ccff chain loader:
//     state_e    - loader FSM state
//     ctrl_t     - bundle of the registered control outputs of the top level
//     DEF_WORD_W - default bitstream word width
// -----------------------------------------------------------------------------
package ccff_loader_pkg;

   localparam int DEF_WORD_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // All-zero is the reset value of every field, including iso_n (pads
   // isolated), so the whole bundle can be cleared with '0.
   typedef struct packed {
      logic ready;     // bs_ready
      logic shift_en;  // ccff_shift_en
      logic busy;
      logic done;
      logic iso_n;     // IO_ISOL_N
   } ctrl_t;

endpackage : ccff_loader_pkg

// File: rtl/ccff_word_serializer.sv
// -----------------------------------------------------------------------------
// ccff_word_serializer
//   Holds one bitstream word and presents it MSB-first, one bit per advance,
//   on a registered head bit.
//
//   clk_i       - clock
//   rst_i       - synchronous active-high reset
//   load_i      - capture data_i; its MSB appears on head_o next cycle
//   adv_i       - present the next bit of the held word on head_o
//   data_i      - word to capture
//   head_o      - registered serial bit (held when neither load nor adv)
//   last_o      - head_o currently carries the final bit of the word
//   nxt_last_o  - head_o will carry the final bit of the word next cycle
// -----------------------------------------------------------------------------
module ccff_word_serializer
   import ccff_loader_pkg::*;
#(
   parameter int WORD_W = DEF_WORD_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic              adv_i,
   input  logic [WORD_W-1:0] data_i,
   output logic              head_o,
   output logic              last_o,
   output logic              nxt_last_o
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);

   // word_q keeps the not-yet-presented bits left-aligned so the next bit
   // is always word_q[WORD_W-1].
   logic [WORD_W-1:0] word_q, word_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              head_q, head_d;

   always_comb begin
      word_d = word_q;
      idx_d  = idx_q;
      head_d = head_q;
      if (load_i) begin
         head_d = data_i[WORD_W-1];
         word_d = data_i << 1;
         idx_d  = '0;
      end else if (adv_i) begin
         head_d = word_q[WORD_W-1];
         word_d = word_q << 1;
         idx_d  = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         word_q <= '0;
         idx_q  <= '0;
         head_q <= 1'b0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
         head_q <= head_d;
      end
   end

   assign head_o     = head_q;
   assign last_o     = (idx_q == IDX_LAST);
   assign nxt_last_o = (idx_d == IDX_LAST);

endmodule : ccff_word_serializer

// File: rtl/ccff_chain_loader.sv
// -----------------------------------------------------------------------------
// ccff_chain_loader
//   Streams a bitstream of WORD_W-bit words into a CHAIN_LEN-bit ccff chain,
//   MSB of each word first, and releases I/O isolation once the whole chain
//   has been loaded. Excess low bits of the final word are dropped.
//
//   prog_clk      - clock
//   prog_reset    - synchronous active-high reset
//   start         - begin a load (honoured in IDLE / DONE only)
//   bs_data       - bitstream word
//   bs_valid      - bs_data valid
//   bs_ready      - word accepted when bs_valid & bs_ready
//   ccff_head     - serial bit into the chain head
//   ccff_shift_en - chain clock enable, high only when ccff_head is valid
//   IO_ISOL_N     - 0 isolates the I/O pads
//   busy          - load in progress
//   done          - sticky, chain fully loaded
// -----------------------------------------------------------------------------
module ccff_chain_loader
   import ccff_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 20,
   parameter int WORD_W    = DEF_WORD_W
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   output logic              IO_ISOL_N,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);

   state_e           state_q, state_d;
   ctrl_t            ctrl_q, ctrl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;

   logic ser_load, ser_adv, ser_last, ser_nxt_last;
   logic hs;

   assign hs = ctrl_q.ready & bs_valid;

   ccff_word_serializer #(
      .WORD_W (WORD_W)
   ) u_ser (
      .clk_i      (prog_clk),
      .rst_i      (prog_reset),
      .load_i     (ser_load),
      .adv_i      (ser_adv),
      .data_i     (bs_data),
      .head_o     (ccff_head),
      .last_o     (ser_last),
      .nxt_last_o (ser_nxt_last)
   );

   // Everything below decides what the *next* cycle shows, so all outputs
   // come straight from flops. cnt_nxt is the number of bits shifted once the
   // current cycle retires; it is also the chain index of the next bit.
   always_comb begin
      state_d  = state_q;
      ctrl_d   = ctrl_q;
      cnt_d    = cnt_q;
      ser_load = 1'b0;
      ser_adv  = 1'b0;
      cnt_nxt  = cnt_q + CNT_W'(ctrl_q.shift_en);

      ctrl_d.shift_en = 1'b0;
      ctrl_d.ready    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_FETCH;
               cnt_d        = '0;
               ctrl_d.done  = 1'b0;
               ctrl_d.busy  = 1'b1;
               ctrl_d.iso_n = 1'b0;
               ctrl_d.ready = 1'b1;
            end
         end

         ST_FETCH, ST_SHIFT: begin
            cnt_d = cnt_nxt;
            if (ctrl_q.shift_en && (cnt_nxt == LEN_C)) begin
               // final chain bit just retired; leftover word bits are dropped
               state_d      = ST_DONE;
               ctrl_d.done  = 1'b1;
               ctrl_d.busy  = 1'b0;
               ctrl_d.iso_n = 1'b1;
            end else if (ctrl_q.shift_en && !ser_last) begin
               state_d         = ST_SHIFT;
               ser_adv         = 1'b1;
               ctrl_d.shift_en = 1'b1;
               // request the next word during its predecessor's last bit so
               // a continuously valid stream shifts without gaps
               ctrl_d.ready    = ser_nxt_last && (cnt_nxt != LAST_C);
            end else if (hs) begin
               state_d         = ST_SHIFT;
               ser_load        = 1'b1;
               ctrl_d.shift_en = 1'b1;
               ctrl_d.ready    = ser_nxt_last && (cnt_nxt != LAST_C);
            end else begin
               // underrun or still waiting for the first word: head holds
               state_d      = ST_FETCH;
               ctrl_d.ready = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            ctrl_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bs_ready      = ctrl_q.ready;
   assign ccff_shift_en = ctrl_q.shift_en;
   assign IO_ISOL_N     = ctrl_q.iso_n;
   assign busy          = ctrl_q.busy;
   assign done          = ctrl_q.done;

endmodule : ccff_chain_loader

// File: tb/tb_ccff_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_ccff_chain_loader
//   Directed bench: instance A uses CHAIN_LEN=20 fed with A5/3C/F0, instance B
//   uses CHAIN_LEN=8 fed with a single 81. Outputs are sampled on the falling
//   edge and inputs are driven right after sampling.
// -----------------------------------------------------------------------------
module tb_ccff_chain_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   // instance A: CHAIN_LEN=20
   logic       rst_a, start_a, valid_a;
   logic [7:0] data_a;
   logic       ready_a, head_a, sen_a, iso_a, busy_a, done_a;

   // instance B: CHAIN_LEN=8
   logic       rst_b, start_b, valid_b;
   logic [7:0] data_b;
   logic       ready_b, head_b, sen_b, iso_b, busy_b, done_b;

   logic [7:0] wa [3];

   ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_a (
      .prog_clk      (clk),
      .prog_reset    (rst_a),
      .start         (start_a),
      .bs_data       (data_a),
      .bs_valid      (valid_a),
      .bs_ready      (ready_a),
      .ccff_head     (head_a),
      .ccff_shift_en (sen_a),
      .IO_ISOL_N     (iso_a),
      .busy          (busy_a),
      .done          (done_a)
   );

   ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut_b (
      .prog_clk      (clk),
      .prog_reset    (rst_b),
      .start         (start_b),
      .bs_data       (data_b),
      .bs_valid      (valid_b),
      .bs_ready      (ready_b),
      .ccff_head     (head_b),
      .ccff_shift_en (sen_b),
      .IO_ISOL_N     (iso_b),
      .busy          (busy_b),
      .done          (done_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic chk_rst_a(input string nm);
      chk({nm, ".head"},  32'(head_a),  32'd0);
      chk({nm, ".sen"},   32'(sen_a),   32'd0);
      chk({nm, ".ready"}, 32'(ready_a), 32'd0);
      chk({nm, ".busy"},  32'(busy_a),  32'd0);
      chk({nm, ".done"},  32'(done_a),  32'd0);
      chk({nm, ".iso_n"}, 32'(iso_a),   32'd0);
   endtask

   // One load on instance A. gap: ready cycles with bs_valid withheld after
   // the first word; poke_at: pulse start after that many bits; rst_at: reset
   // after that many bits and abandon the load.
   task automatic run_a(input string nm, input int gap, input int poke_at, input int rst_at,
                        input int exp_span, input int exp_rdy);
      logic [31:0] bits;
      int nb, hs, rdy, first, last, gl, widx, dcyc;
      bit fin, abort;
      bits = '0; nb = 0; hs = 0; rdy = 0; first = -1; last = -1;
      gl = gap; widx = 0; dcyc = -1; fin = 1'b0; abort = 1'b0;

      @(negedge clk);
      start_a = 1'b1;
      valid_a = 1'b0;
      @(negedge clk);
      start_a = 1'b0;
      chk({nm, ".start_busy"}, 32'(busy_a), 32'd1);
      chk({nm, ".start_done"}, 32'(done_a), 32'd0);
      chk({nm, ".start_iso"},  32'(iso_a),  32'd0);

      for (int cyc = 0; cyc < 200 && !fin && !abort; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (done_a) begin
            fin  = 1'b1;
            dcyc = cyc;
            chk({nm, ".done_iso"},   32'(iso_a),   32'd1);
            chk({nm, ".done_busy"},  32'(busy_a),  32'd0);
            chk({nm, ".done_sen"},   32'(sen_a),   32'd0);
            chk({nm, ".done_ready"}, 32'(ready_a), 32'd0);
         end else begin
            if (sen_a) begin
               bits = {bits[30:0], head_a};
               nb++;
               if (first < 0) first = cyc;
               last = cyc;
            end else if (nb > 0) begin
               chk({nm, ".head_hold"}, 32'(head_a), 32'(bits[0]));
            end
            if (ready_a) rdy++;
            start_a = sen_a && (nb == poke_at);
            if (rst_at >= 0 && nb == rst_at) begin
               // reset together with start and a valid word: reset must win
               rst_a   = 1'b1;
               start_a = 1'b1;
               valid_a = 1'b1;
               data_a  = wa[0];
               @(negedge clk);
               chk_rst_a({nm, ".rst"});
               rst_a   = 1'b0;
               start_a = 1'b0;
               valid_a = 1'b0;
               abort   = 1'b1;
            end else begin
               valid_a = (widx < 3) && !(widx == 1 && gl > 0 && ready_a);
               if (widx == 1 && gl > 0 && ready_a) gl--;
               data_a = (widx < 3) ? wa[widx] : 8'h00;
               if (ready_a && valid_a) begin
                  hs++;
                  widx++;
               end
            end
         end
      end
      start_a = 1'b0;
      valid_a = 1'b0;
      chk({nm, ".terminated"}, 32'(fin | abort), 32'd1);
      if (fin) begin
         chk({nm, ".bits"},      bits,      32'h000A53CF);
         chk({nm, ".nbits"},     nb,        20);
         chk({nm, ".handshake"}, hs,        3);
         chk({nm, ".first_bit"}, first,     1);
         chk({nm, ".span"},      last - first + 1, exp_span);
         chk({nm, ".done_at"},   dcyc,      last + 1);
         chk({nm, ".ready_cyc"}, rdy,       exp_rdy);
      end
   endtask

   logic [31:0] bits_b;
   int nb_b, hs_b, rdy_b, first_b, last_b, dcyc_b;
   bit fin_b;

   initial begin
      wa[0] = 8'hA5; wa[1] = 8'h3C; wa[2] = 8'hF0;
      rst_a = 1'b1; start_a = 1'b0; valid_a = 1'b0; data_a = 8'h00;
      rst_b = 1'b1; start_b = 1'b0; valid_b = 1'b0; data_b = 8'h00;
      repeat (2) @(negedge clk);
      chk_rst_a("por_a");
      chk("por_b.outs", 32'({head_b, sen_b, ready_b, busy_b, done_b, iso_b}), 32'd0);
      rst_a = 1'b0;
      rst_b = 1'b0;
      @(negedge clk);
      chk("idle_a.sen_ready", 32'({sen_a, ready_a}), 32'd0);

      run_a("stream",     0, -1, -1, 20, 3);
      run_a("restart",    0, -1, -1, 20, 3);
      run_a("underrun",   3, -1, -1, 23, 6);
      run_a("start_mid",  0,  5, -1, 20, 3);
      run_a("reset_mid",  0, -1, 10, 0,  0);
      run_a("after_rst",  0, -1, -1, 20, 3);

      // instance B: single word, chain shorter than nothing left over
      bits_b = '0; nb_b = 0; hs_b = 0; rdy_b = 0; first_b = -1; last_b = -1;
      dcyc_b = -1; fin_b = 1'b0;
      @(negedge clk);
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      for (int cyc = 0; cyc < 60 && !fin_b; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (done_b) begin
            fin_b  = 1'b1;
            dcyc_b = cyc;
            chk("short.done_iso",  32'(iso_b),  32'd1);
            chk("short.done_busy", 32'(busy_b), 32'd0);
         end else begin
            if (sen_b) begin
               bits_b = {bits_b[30:0], head_b};
               nb_b++;
               if (first_b < 0) first_b = cyc;
               last_b = cyc;
            end
            if (ready_b && hs_b > 0) rdy_b++;
            valid_b = 1'b1;
            data_b  = (hs_b == 0) ? 8'h81 : 8'hFF;
            if (ready_b && valid_b) hs_b++;
         end
      end
      valid_b = 1'b0;
      chk("short.terminated",  32'(fin_b), 32'd1);
      chk("short.bits",        bits_b,     32'h00000081);
      chk("short.nbits",       nb_b,       8);
      chk("short.handshake",   hs_b,       1);
      chk("short.ready_after", rdy_b,      0);
      chk("short.first_bit",   first_b,    1);
      chk("short.done_at",     dcyc_b,     last_b + 1);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

endmodule : tb_ccff_chain_loader

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 Parameter CHAIN_LEN, default 20: total number of configuration bits in the downstream ccff chain, legal range 1..65535.
REQ-002 Parameter WORD_W, default 8: width in bits of one bitstream word.
REQ-003 prog_clk  input  1  the one clock; all state updates on its rising edge.
REQ-004 prog_reset  input  1  synchronous, active-high reset, sampled on the prog_clk rising edge.
REQ-005 start  input  1  single-cycle request to begin a load, honoured only in IDLE or DONE.
REQ-006 bs_data  input  WORD_W  bitstream word; bit WORD_W-1 is shifted out first.
REQ-007 bs_valid  input  1  bs_data is valid.
REQ-008 bs_ready  output  1  loader accepts a word this cycle; transfer occurs when bs_valid and bs_ready are both 1.
REQ-009 ccff_head  output  1  serial configuration bit driven into the chain head.
REQ-010 ccff_shift_en  output  1  chain clock enable; 1 exactly in cycles where ccff_head carries a valid bit.
REQ-011 IO_ISOL_N  output  1  I/O isolation control; 0 isolates the I/O pads.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  sticky; full chain loaded.

Function
REQ-014 The block SHALL implement a four-state FSM: IDLE, FETCH, SHIFT, DONE.
REQ-015 On start in IDLE or DONE, the block SHALL go to FETCH, clear done, clear the bit counter, drive IO_ISOL_N=0 and set busy=1; start in FETCH or SHIFT SHALL be ignored.
REQ-016 In FETCH, bs_ready SHALL be 1; a handshake SHALL load the word register and go to SHIFT.
REQ-017 A word accepted in cycle N SHALL have its MSB on ccff_head with ccff_shift_en=1 in cycle N+1, then one bit per cycle, MSB-first.
REQ-018 bs_ready SHALL also be 1 during the last bit cycle of a word, provided further bits remain in the chain, so that streaming with bs_valid held high gives gap-free shifting.
REQ-019 Underrun (no word available when one is needed) SHALL drop ccff_shift_en to 0, hold the bit counter and ccff_head, and stay in FETCH.
REQ-020 The total bit counter SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and increment once per ccff_shift_en=1 cycle.
REQ-021 The block SHALL accept exactly ceil(CHAIN_LEN/WORD_W) words; unused low bits of the final word SHALL be discarded and never shifted out.
REQ-022 The cycle after the CHAIN_LEN-th shifted bit, the block SHALL enter DONE with done=1, busy=0, IO_ISOL_N=1, ccff_shift_en=0 and bs_ready=0.
REQ-023 In IDLE and DONE, ccff_shift_en and bs_ready SHALL be 0.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 prog_reset=1 SHALL force: state IDLE, ccff_head=0, ccff_shift_en=0, bs_ready=0, busy=0, done=0, IO_ISOL_N=0, all counters 0.
REQ-026 Reset during FETCH or SHIFT SHALL abort the load and leave IO_ISOL_N=0 until a later load completes.
REQ-027 prog_reset SHALL take priority over start and over a handshake in the same cycle.

Structure
REQ-028 Package ccff_loader_pkg SHALL hold the FSM state enum and the WORD_W default.
REQ-029 Sub-module ccff_word_serializer SHALL contain the word register, the per-word bit counter and MSB-first shift logic; the top level SHALL contain the FSM and the total bit counter.

Verification
REQ-030 CHAIN_LEN=20; words 0xA5, 0x3C, 0xF0 with bs_valid held high -> ccff_head = 10100101 00111100 1111 over 20 contiguous shift_en cycles; done=1 and IO_ISOL_N=1 on the next cycle; exactly 3 handshakes.
REQ-031 Same stream with bs_valid low for 3 cycles after the first word -> ccff_shift_en low for 3 cycles after bit 8; the bit sequence is unchanged; 20 shift_en cycles in total.
REQ-032 Reset asserted after 10 shifted bits -> next cycle all outputs at their reset values; a subsequent start reloads all 20 bits from bit 0.
REQ-033 start pulsed during SHIFT -> no effect on the bit count, the shifted sequence or the done timing.
REQ-034 CHAIN_LEN=8, one word 0x81 -> ccff_head = 10000001; done after 8 shift cycles; bs_ready never 1 after the handshake.
REQ-035 start from DONE -> done cleared and IO_ISOL_N=0 the next cycle; the second load completes identically to the first.
